json_uart_rx_parser: RTL and testbench
======================================

// Module: json_uart_rx_parser
// PURPOSE
//   UART receiver and streaming parser for rover JSON command/feedback lines of the form
//   {"T":<int>,"L":<num>,"R":<num>}\n, the receive end of the JSON-over-UART motor link.
//   Samples the GPIO RX line and parses each byte in flight; no line buffer is kept.
//   Emits T plus L/R as signed fixed-point hundredths with a one-cycle valid strobe.
// PARAMETERS
//   CLKS_PER_BIT    434      clk cycles per UART bit (115200 baud @ 50 MHz), 8N1 framing
//   TIMEOUT_CYCLES  100_000  max idle clks between bytes inside a frame; 0 = timeout disabled
// PORTS
//   clk        in   1   system clock
//   rst        in   1   reset, asynchronous, active-high
//   uart_in    in   1   raw RX line (asynchronous, idle high)
//   msg_valid  out  1   1-clk pulse: a complete, well-formed frame was parsed
//   msg_t      out  8   T value (unsigned 0..255); held until next msg_valid
//   msg_l      out  16  L, signed, units of 0.01; held until next msg_valid
//   msg_r      out  16  R, signed, units of 0.01; held until next msg_valid
//   parse_err  out  1   1-clk pulse: frame aborted (syntax, range, UART framing, timeout)
//   busy       out  1   high while a frame is in progress (after '{' until end or abort)
// BEHAVIOUR
//   Reset: all outputs 0; parser to IDLE; accumulators cleared; timeout counter cleared.
//   RX: 2-flop synchroniser, start-bit detect, mid-bit sampling; bad stop bit = framing error.
//   Each received byte is consumed in the clk after the RX byte strobe (one byte/strobe).
//   Accepted grammar: keys in fixed order T, L, R; ' ' (0x20) and CR (0x0D) ignored outside numbers.
//   FSM: IDLE -'{'-> KQ1 -'"'-> KEY (must be next expected key) -> KQ2 -'"'-> COLON -':'-> NSIGN
//     NSIGN: '-' sets neg (L/R only) -> NINT; digit -> NINT.
//     NINT: 1-2 digits; '.' -> NFRAC (L/R only); ',' -> KQ1 after T/L; '}' -> EOL after R.
//     NFRAC: 0-2 digits, then ',' or '}' as above.
//     EOL: '\n' -> IDLE and pulse msg_valid.
//   Value = int*100 + frac (one frac digit is scaled x10); negated if neg; range +/-99.99.
//     T: 1-3 digits, no sign or '.', must be <= 255.
//   msg_t/l/r and msg_valid update together in the clk after the '\n' strobe.
//   Errors: unexpected char, missing digits ("-", "."), too many digits, T>255,
//     space inside a number, UART framing error, or timeout while busy.
//     Action: parse_err pulse, outputs untouched, FSM -> IDLE.
//   '{' in any state other than IDLE restarts the frame. In a non-IDLE state this also pulses parse_err.
//   '\n' in IDLE is ignored silently. Any other byte in IDLE is discarded with no error.
//   Simultaneous timeout and byte strobe: the byte wins and the counter reloads.
//   Reset mid-frame discards the partial frame; no msg_valid or parse_err is produced for it.
// CONFIGURATION
//   JSON_RX_ERRCNT_EN defined: adds port err_count out 16.
//     err_count is a saturating count of parse_err pulses (sticks at 16'hFFFF); reset to 0.
//   Undefined: the port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//   Package json_uart_pkg:
//     ASCII constants ('{','}','"',':',',','-','.','\n',' ',CR).
//     Parser state enum; FIXED_W=16; key enum {KEY_T,KEY_L,KEY_R}.
//   Sub-module uart_rx:
//     params CLKS_PER_BIT, BITS_N=8.
//     Outputs data_rx[7:0], valid (1-clk pulse), frame_err (1-clk pulse).
//   The parser FSM, timeout counter and accumulators live in this module.
// TESTING
//   {"T":1,"L":0.5,"R":0.5}\n -> one msg_valid; t=1, l=50, r=50; parse_err never asserted.
//   {"T":1,"L":-0.00,"R":0.12}\r\n -> l=0, r=12.
//   Then {"T":1,"L":0,"R":0}\n -> l=0, r=0; each valid arrives 1 clk after its '\n' strobe.
//   {"T":1,"X":0}\n -> parse_err on 'X'; no msg_valid; outputs keep prior frame.
//     A following good frame parses correctly.
//   "L":0.125 and "L":123 and "T":256 -> parse_err each.
//   "L":-12.5 -> l=-1250 (16'hFB1E).
//   Half frame, then idle > TIMEOUT_CYCLES -> single parse_err, busy drops.
//     Stop bit forced low -> parse_err.
//   rst mid-frame -> all outputs 0, no pulses.
//     With JSON_RX_ERRCNT_EN defined, err_count tracks the pulses above exactly.

Source files
------------

// File: rtl/json_uart_pkg.sv
// Shared definitions for the JSON-over-UART receive path: ASCII tokens, parser/receiver states, key ids.
package json_uart_pkg;

  localparam int FIXED_W = 16;

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;

  typedef enum logic [3:0] {
    S_IDLE, S_KQ1, S_KEY, S_KQ2, S_COLON, S_NSIGN, S_NINT, S_NFRAC, S_EOL
  } parse_state_e;

  typedef enum logic [1:0] {KEY_T, KEY_L, KEY_R} key_e;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  function automatic logic [7:0] key_char(input key_e k);
    case (k)
      KEY_T:   return 8'h54;
      KEY_L:   return 8'h4C;
      default: return 8'h52;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_ZERO) && (b <= CH_NINE);
  endfunction

  function automatic logic is_blank(input logic [7:0] b);
    return (b == CH_SPACE) || (b == CH_CR);
  endfunction

endpackage

// File: rtl/json_uart_rx_parser_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit qualification, mid-bit sampling, stop-bit check.
module uart_rx
  import json_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BITS_N-1:0] data_rx,
  output logic              valid,
  output logic              frame_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS_N - 1);

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic [BITS_N-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // NOTE: every sequential block uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;  // high at mid-start: glitch, not a start bit
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[BITS_N-1:1]};
          if (idx_q == LAST_IDX) state_d = RX_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        // A low stop bit must not be mistaken for the next start bit.
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_rx   = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/json_uart_rx_parser.sv
// Receives {"T":<int>,"L":<num>,"R":<num>}\n lines over UART and parses them on the fly.
// Optional JSON_RX_ERRCNT_EN adds a saturating err_count output.
module json_uart_rx_parser
  import json_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_in,
  output logic               msg_valid,
  output logic [7:0]         msg_t,
  output logic [FIXED_W-1:0] msg_l,
  output logic [FIXED_W-1:0] msg_r,
  output logic               parse_err,
  output logic               busy
`ifdef JSON_RX_ERRCNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .BITS_N       (8)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_in),
    .data_rx   (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  parse_state_e       state_q, state_d;
  key_e               key_q, key_d;
  logic               neg_q, neg_d;
  logic [9:0]         int_q, int_d;
  logic [1:0]         int_cnt_q, int_cnt_d;
  logic [6:0]         frac_q, frac_d;
  logic [1:0]         frac_cnt_q, frac_cnt_d;
  logic [7:0]         t_q, t_d;
  logic [FIXED_W-1:0] l_q, l_d, r_q, r_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               msg_valid_q, msg_valid_d;
  logic [7:0]         msg_t_q, msg_t_d;
  logic [FIXED_W-1:0] msg_l_q, msg_l_d, msg_r_q, msg_r_d;
  logic               parse_err_q, parse_err_d;

  logic [3:0]         digit;
  logic [9:0]         int_next;
  logic [1:0]         int_max;
  logic [FIXED_W-1:0] mag;
  logic [FIXED_W-1:0] value;
  logic               err;
  logic               restart;
  logic               commit;

  assign digit    = rx_data[3:0];
  assign int_next = int_q * 10'd10 + {6'd0, digit};
  assign int_max  = (key_q == KEY_T) ? 2'd3 : 2'd2;
  // Fraction is kept pre-scaled to hundredths, so the value is a plain sum.
  assign mag      = FIXED_W'(int_q) * FIXED_W'(100) + FIXED_W'(frac_q);
  assign value    = neg_q ? -mag : mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= KEY_T;
      neg_q       <= 1'b0;
      int_q       <= '0;
      int_cnt_q   <= '0;
      frac_q      <= '0;
      frac_cnt_q  <= '0;
      t_q         <= '0;
      l_q         <= '0;
      r_q         <= '0;
      tmo_q       <= '0;
      msg_valid_q <= 1'b0;
      msg_t_q     <= '0;
      msg_l_q     <= '0;
      msg_r_q     <= '0;
      parse_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      neg_q       <= neg_d;
      int_q       <= int_d;
      int_cnt_q   <= int_cnt_d;
      frac_q      <= frac_d;
      frac_cnt_q  <= frac_cnt_d;
      t_q         <= t_d;
      l_q         <= l_d;
      r_q         <= r_d;
      tmo_q       <= tmo_d;
      msg_valid_q <= msg_valid_d;
      msg_t_q     <= msg_t_d;
      msg_l_q     <= msg_l_d;
      msg_r_q     <= msg_r_d;
      parse_err_q <= parse_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    neg_d       = neg_q;
    int_d       = int_q;
    int_cnt_d   = int_cnt_q;
    frac_d      = frac_q;
    frac_cnt_d  = frac_cnt_q;
    t_d         = t_q;
    l_d         = l_q;
    r_d         = r_q;
    tmo_d       = tmo_q;
    msg_valid_d = 1'b0;
    msg_t_d     = msg_t_q;
    msg_l_d     = msg_l_q;
    msg_r_d     = msg_r_q;
    parse_err_d = 1'b0;
    err         = 1'b0;
    restart     = 1'b0;
    commit      = 1'b0;

    if (rx_valid) begin
      tmo_d = '0;
      if (rx_data == CH_LBRACE) begin
        restart = 1'b1;
        err     = (state_q != S_IDLE);
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_KQ1: begin
            if (rx_data == CH_QUOTE)     state_d = S_KEY;
            else if (!is_blank(rx_data)) err     = 1'b1;
          end
          S_KEY: begin
            if (rx_data == key_char(key_q)) state_d = S_KQ2;
            else                            err     = 1'b1;
          end
          S_KQ2: begin
            if (rx_data == CH_QUOTE) state_d = S_COLON;
            else                     err     = 1'b1;
          end
          S_COLON: begin
            if (rx_data == CH_COLON) begin
              state_d    = S_NSIGN;
              neg_d      = 1'b0;
              int_d      = '0;
              int_cnt_d  = '0;
              frac_d     = '0;
              frac_cnt_d = '0;
            end else if (!is_blank(rx_data)) begin
              err = 1'b1;
            end
          end
          S_NSIGN: begin
            if (rx_data == CH_MINUS && key_q != KEY_T) begin
              neg_d   = 1'b1;
              state_d = S_NINT;
            end else if (is_digit(rx_data)) begin
              int_d     = {6'd0, digit};
              int_cnt_d = 2'd1;
              state_d   = S_NINT;
            end else if (!is_blank(rx_data)) begin
              err = 1'b1;
            end
          end
          S_NINT: begin
            if (is_digit(rx_data)) begin
              int_d     = int_next;
              int_cnt_d = int_cnt_q + 2'd1;
              err       = (int_cnt_q == int_max) || (key_q == KEY_T && int_next > 10'd255);
            end else if (int_cnt_q == 2'd0) begin
              err = 1'b1;  // sign with no digits
            end else if (rx_data == CH_DOT && key_q != KEY_T) begin
              state_d = S_NFRAC;
            end else if ((rx_data == CH_COMMA && key_q != KEY_R) ||
                         (rx_data == CH_RBRACE && key_q == KEY_R)) begin
              commit = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
          S_NFRAC: begin
            if (is_digit(rx_data)) begin
              frac_cnt_d = frac_cnt_q + 2'd1;
              frac_d     = (frac_cnt_q == 2'd0) ? 7'(digit) * 7'd10 : frac_q + 7'(digit);
              err        = (frac_cnt_q == 2'd2);
            end else if ((rx_data == CH_COMMA && key_q == KEY_L) ||
                         (rx_data == CH_RBRACE && key_q == KEY_R)) begin
              commit = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
          S_EOL: begin
            if (rx_data == CH_LF) begin
              state_d     = S_IDLE;
              msg_valid_d = 1'b1;
              msg_t_d     = t_q;
              msg_l_d     = l_q;
              msg_r_d     = r_q;
            end else if (!is_blank(rx_data)) begin
              err = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (rx_ferr) begin
      err = (state_q != S_IDLE);
    end else if (state_q != S_IDLE && TIMEOUT_CYCLES != 0) begin
      if (tmo_q == TMO_LIMIT) err   = 1'b1;
      else                    tmo_d = tmo_q + 1'b1;
    end

    if (commit) begin
      unique case (key_q)
        KEY_T: begin
          t_d     = int_q[7:0];
          key_d   = KEY_L;
          state_d = S_KQ1;
        end
        KEY_L: begin
          l_d     = value;
          key_d   = KEY_R;
          state_d = S_KQ1;
        end
        default: begin
          r_d     = value;
          state_d = S_EOL;
        end
      endcase
    end

    if (state_q == S_IDLE && !restart) tmo_d = '0;

    if (err) begin
      parse_err_d = 1'b1;
      state_d     = S_IDLE;
      tmo_d       = '0;
    end
    if (restart) begin
      state_d = S_KQ1;
      key_d   = KEY_T;
    end
  end

`ifdef JSON_RX_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (parse_err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign msg_valid = msg_valid_q;
  assign msg_t     = msg_t_q;
  assign msg_l     = msg_l_q;
  assign msg_r     = msg_r_q;
  assign parse_err = parse_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_json_uart_rx_parser.sv
// Scoreboard bench: stimulus pushes expected msg/err events; a negedge monitor pops and compares.
module tb_json_uart_rx_parser;

  localparam int CPB = 8;
  localparam int TMO = 1000;

  logic        clk;
  logic        rst;
  logic        uart_in;
  logic        msg_valid;
  logic [7:0]  msg_t;
  logic [15:0] msg_l;
  logic [15:0] msg_r;
  logic        parse_err;
  logic        busy;
`ifdef JSON_RX_ERRCNT_EN
  logic [15:0] err_count;
`endif

  json_uart_rx_parser #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_in   (uart_in),
    .msg_valid (msg_valid),
    .msg_t     (msg_t),
    .msg_l     (msg_l),
    .msg_r     (msg_r),
    .parse_err (parse_err),
    .busy      (busy)
`ifdef JSON_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [7:0]  t;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_errs = 0;
  logic [7:0]  last_t   = '0;
  logic [15:0] last_l   = '0;
  logic [15:0] last_r   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic push_msg(input int t, input int l, input int r);
    last_t = 8'(t);
    last_l = 16'(l);
    last_r = 16'(r);
    exp_q.push_back('{1'b0, last_t, last_l, last_r});
  endtask

  task automatic push_err();
    exp_q.push_back('{1'b1, last_t, last_l, last_r});
    exp_errs++;
  endtask

  task automatic drive_bit(input logic v);
    uart_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (!stop_bit) drive_bit(1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic gap();
    repeat (20) @(negedge clk);
  endtask

  // Monitor: every msg_valid / parse_err pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (msg_valid || parse_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, msg_valid, parse_err}, 32'd0);
      end else begin
        got = exp_q.pop_front();
        check("event_kind", {30'd0, msg_valid, parse_err}, got.is_err ? 32'd1 : 32'd2);
        check("msg_t", {24'd0, msg_t}, {24'd0, got.t});
        check("msg_l", {16'd0, msg_l}, {16'd0, got.l});
        check("msg_r", {16'd0, msg_r}, {16'd0, got.r});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    uart_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_msg_valid", {31'd0, msg_valid}, 32'd0);
    check("rst_parse_err", {31'd0, parse_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outputs", {msg_t, msg_l[7:0], msg_r[7:0], 8'd0}, 32'd0);
    rst = 1'b0;
    gap();

    push_msg(1, 50, 50);
    send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
    gap();
    push_msg(1, 0, 12);
    send_str("{\"T\":1,\"L\":-0.00,\"R\":0.12}\r\n");
    gap();
    push_msg(1, 0, 0);
    send_str("{\"T\":1,\"L\":0,\"R\":0}\n");
    gap();

    push_err();
    send_str("{\"T\":1,\"X\":0}\n");
    gap();
    push_msg(7, -1250, 9999);
    send_str("{\"T\":7,\"L\":-12.5,\"R\":99.99}\n");
    gap();
    check("neg_12_5_bits", {16'd0, msg_l}, 32'h0000FB1E);

    push_err();
    send_str("{\"T\":2,\"L\":0.125,\"R\":0}\n");
    gap();
    push_err();
    send_str("{\"T\":3,\"L\":123,\"R\":0}\n");
    gap();
    push_err();
    send_str("{\"T\":256,\"L\":0,\"R\":0}\n");
    gap();
    push_err();
    send_str("{\"T\":1,\"L\":-,\"R\":0}\n");
    gap();
    push_msg(255, -9999, -50);
    send_str("{\"T\":255,\"L\":-99.99,\"R\":-0.5}\n");
    gap();

    push_err();
    push_msg(5, 100, 200);
    send_str("{\"T\":4,{\"T\":5,\"L\":1,\"R\":2}\n");
    gap();
    push_err();
    send_str("{\"T\":6,\"L\": 1 ,\"R\":0}\n");
    gap();

    push_err();
    send_str("{\"T\":1,");
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    gap();

    push_err();
    send_str("{\"T\":1");
    send_byte(8'h2C, 1'b0);
    gap();
    check("busy_after_frame_err", {31'd0, busy}, 32'd0);
`ifdef JSON_RX_ERRCNT_EN
    check("err_count", {16'd0, err_count}, 32'(exp_errs));
`endif

    send_str("{\"T\":9,\"L\":");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_outputs", {msg_t, msg_l[7:0], msg_r[7:0], 8'd0}, 32'd0);
    check("midrst_hi_bytes", {msg_l[15:8], msg_r[15:8], 16'd0}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
`ifdef JSON_RX_ERRCNT_EN
    check("err_count_rst", {16'd0, err_count}, 32'd0);
`endif
    rst      = 1'b0;
    last_t   = '0;
    last_l   = '0;
    last_r   = '0;
    exp_errs = 0;
    gap();

    push_msg(8, 10, -100);
    send_str("{\"T\":8,\"L\":0.1,\"R\":-1}\n");
    repeat (50) @(negedge clk);
`ifdef JSON_RX_ERRCNT_EN
    check("err_count_final", {16'd0, err_count}, 32'(exp_errs));
`endif
    check("events_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
